// File: rtl/bus_pkg.sv
// Shared types and constants for the single-master bus fabric.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int LAT_W = 2;

  // System address map
  localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
  localparam logic [31:0] ROM_MASK   = 32'hFFFF_0000;
  localparam logic [31:0] RAM_BASE   = 32'h0001_0000;
  localparam logic [31:0] RAM_MASK   = 32'hFFFF_0000;
  localparam logic [31:0] EXCP_BASE  = 32'h0002_0000;
  localparam logic [31:0] EXCP_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] PORTA_BASE = 32'h0003_0000;
  localparam logic [31:0] PORTA_MASK = 32'hFFFF_FFF0;
  localparam logic [31:0] PORTB_BASE = 32'h0003_0010;
  localparam logic [31:0] PORTB_MASK = 32'hFFFF_FFF0;
  localparam logic [31:0] T0_BASE    = 32'h0004_0000;
  localparam logic [31:0] T0_MASK    = 32'hFFFF_FFF0;
  // Unused slots: zero mask against a non-zero base never matches
  localparam logic [31:0] NONE_BASE  = 32'hFFFF_FFFF;
  localparam logic [31:0] NONE_MASK  = 32'h0000_0000;

  localparam logic [8*32-1:0] DEF_BASE = {NONE_BASE, NONE_BASE, T0_BASE, PORTB_BASE,
                                          PORTA_BASE, EXCP_BASE, RAM_BASE, ROM_BASE};
  localparam logic [8*32-1:0] DEF_MASK = {NONE_MASK, NONE_MASK, T0_MASK, PORTB_MASK,
                                          PORTA_MASK, EXCP_MASK, RAM_MASK, ROM_MASK};

  // Select index width; a single slave still needs one bit
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_fabric_if.sv
// Bus signals between CPU, fabric and slaves.
interface bus_fabric_if #(
  parameter int NUM_SLAVES = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  logic                         m_req;
  logic                         m_we;
  logic [ADDR_W-1:0]            m_addr;
  logic [DATA_W-1:0]            m_wdata;
  logic [DATA_W-1:0]            m_rdata;
  logic                         m_ready;
  logic                         m_err;
  logic [NUM_SLAVES-1:0]        s_cs;
  logic [NUM_SLAVES-1:0]        s_we;
  logic [ADDR_W-1:0]            s_addr;
  logic [DATA_W-1:0]            s_wdata;
  logic [NUM_SLAVES*DATA_W-1:0] s_rdata;

  // CPU side
  modport master (output m_req, m_we, m_addr, m_wdata,
                  input  m_rdata, m_ready, m_err);
  // Fabric side: responds to the CPU and drives the peripheral pins
  modport slave  (input  m_req, m_we, m_addr, m_wdata, s_rdata,
                  output m_rdata, m_ready, m_err, s_cs, s_we, s_addr, s_wdata);
endinterface

// File: rtl/bus_addr_decode.sv
// Combinational base/mask address match; lowest matching index wins.
module bus_addr_decode #(
  parameter int                            NUM_SLAVES = 8,
  parameter int                            ADDR_W     = 32,
  parameter int                            SEL_W      = 3,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_MASK = '0
) (
  input  logic [ADDR_W-1:0] m_addr_i,
  output logic              hit_o,
  output logic [SEL_W-1:0]  sel_o
);

  // Scan high to low so the lowest overlapping slave takes the last write
  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    for (int i = NUM_SLAVES-1; i >= 0; i--) begin
      if ((m_addr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        hit_o = 1'b1;
        sel_o = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Single-master interconnect: decode, per-slave wait states, registered
// read return and sticky capture of unmapped accesses.
module bus_fabric import bus_pkg::*; #(
  parameter int                           NUM_SLAVES = 8,
  parameter int                           ADDR_W     = 32,
  parameter int                           DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEF_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = DEF_MASK,
  parameter logic [NUM_SLAVES*2-1:0]      SLAVE_LAT  = '0
) (
  input  logic              clk,
  input  logic              rst,
  bus_fabric_if.slave       bus,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              err_clear
);

  localparam int SEL_W = sel_w(NUM_SLAVES);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, err_addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic                we_q, first_q, err_q, err_valid_q;
  logic [SEL_W-1:0]    sel_q, sel;
  logic [LAT_W-1:0]    cnt_q;
  logic                hit;

  bus_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SEL_W      (SEL_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_dec (
    .m_addr_i (bus.m_addr),
    .hit_o    (hit),
    .sel_o    (sel)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state: unmapped requests skip ACCESS
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.m_req) state_d = hit ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request latches, wait counter and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.m_req) begin
          addr_q  <= bus.m_addr;
          wdata_q <= bus.m_wdata;
          we_q    <= bus.m_we;
          sel_q   <= sel;
          cnt_q   <= SLAVE_LAT[sel*LAT_W +: LAT_W];
          first_q <= 1'b1;
          if (!hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        ST_ACCESS: begin
          first_q <= 1'b0;
          if (cnt_q == '0) begin
            rdata_q <= we_q ? '0 : bus.s_rdata[sel_q*DATA_W +: DATA_W];
            err_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky unmapped-access capture; a new error beats a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else if (state_q == ST_IDLE && bus.m_req && !hit) begin
      err_valid_q <= 1'b1;
      if (!err_valid_q || err_clear) err_addr_q <= bus.m_addr;
    end else if (err_clear) begin
      err_valid_q <= 1'b0;
    end
  end

  // Strobes decoded from state: select for the whole ACCESS, write on its first cycle
  always_comb begin
    bus.m_ready = (state_q == ST_RESP);
    bus.s_cs    = '0;
    bus.s_we    = '0;
    if (state_q == ST_ACCESS) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        bus.s_cs[i] = (sel_q == SEL_W'(i));
        bus.s_we[i] = (sel_q == SEL_W'(i)) && we_q && first_q;
      end
    end
  end

  assign bus.m_rdata = rdata_q;
  assign bus.m_err   = err_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_wdata = wdata_q;
  assign err_valid   = err_valid_q;
  assign err_addr    = err_addr_q;

endmodule
